// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of one shared UART transmitter.
// Each requester has a one-byte holding slot. A granted byte is launched with a
// one-cycle tx_start. The arbiter then waits for the transmitter to finish, with
// a timeout on busy rising, and holds an idle gap before the next grant.
// Optional build macro: UART_TX_ARB_ROUND_ROBIN_EN. When it is defined, the
// winner alternates if both requesters are pending. When it is not defined,
// requester 0 has fixed priority.
module uart_tx_arbiter #(
  parameter int unsigned GAP_CYCLES   = 16,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       grant_id,
  output logic       ack0,
  output logic       ack1,
  output logic       drop0,
  output logic       drop1,
  output logic       active
);

  localparam int unsigned CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pend0, pend1;
  logic [7:0]    hold0, hold1;
  logic          grant_v, win;
  logic          take0, take1, slot0_free, slot1_free;

  // Winner selection and slot availability for this cycle
  always_comb begin
    grant_v = (state == IDLE) && !tx_busy && (pend0 || pend1);
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    win = (pend0 && pend1) ? ~grant_id : ~pend0;
`else
    win = ~pend0;
`endif
    take0 = grant_v && !win;
    take1 = grant_v && win;
    // A slot being granted this cycle frees up on the same edge, so a new strobe refills it.
    slot0_free = !pend0 || take0;
    slot1_free = !pend1 || take1;
  end

  // Next-state and shared wait/gap counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (grant_v) state_nxt = START;
      end
      START: begin
        state_nxt = WAIT_BUSY;
        cnt_nxt   = '0;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (32'(cnt) + 32'd1 >= BUSY_TIMEOUT) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (32'(cnt) + 32'd1 >= GAP_CYCLES) state_nxt = IDLE;
        else                                cnt_nxt   = cnt + CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Holding slots, issued byte, owner and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      pend0    <= 1'b0;
      pend1    <= 1'b0;
      hold0    <= '0;
      hold1    <= '0;
      tx_data  <= '0;
      grant_id <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      drop0    <= 1'b0;
      drop1    <= 1'b0;
    end else begin
      ack0  <= take0;
      ack1  <= take1;
      drop0 <= req0 && !slot0_free;
      drop1 <= req1 && !slot1_free;
      if (grant_v) begin
        tx_data  <= win ? hold1 : hold0;
        grant_id <= win;
      end
      if (req0 && slot0_free) begin
        pend0 <= 1'b1;
        hold0 <= data0;
      end else if (take0) begin
        pend0 <= 1'b0;
      end
      if (req1 && slot1_free) begin
        pend1 <= 1'b1;
        hold1 <= data1;
      end else if (take1) begin
        pend1 <= 1'b0;
      end
    end
  end

  assign tx_start = (state == START);
  assign active   = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. It contains a timestamp-based reference model,
// a per-cycle output compare, directed literal scenarios, and a randomized
// traffic phase. A responder stands in for the UART transmitter and drives tx_busy.
module tb_uart_tx_arbiter;
  localparam int GAP = 16;
  localparam int BT  = 8;
  localparam int G   = (GAP < 1) ? 1 : GAP;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, req0, req1, tx_busy;
  logic [7:0] data0, data1;
  logic       tx_start, grant_id, ack0, ack1, drop0, drop1, active;
  logic [7:0] tx_data;

  uart_tx_arbiter #(.GAP_CYCLES(GAP), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .grant_id(grant_id),
    .ack0(ack0), .ack1(ack1), .drop0(drop0), .drop1(drop1), .active(active)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // reference model state
  bit       m_ok = 1'b0;
  bit       mp0, mp1, m_xfer, m_rise;
  logic [7:0] md0, md1;
  int       m_S, m_rise_cyc, m_free;
  logic       e_start, e_gid, e_ack0, e_ack1, e_drop0, e_drop1, e_active;
  logic [7:0] e_data;

  // transmitter responder configuration
  bit rsp_rand  = 1'b0;
  int rsp_delay = 3;
  int rsp_len   = 4;
  int rise_at   = -1;
  int fall_at   = -1;

  // event log
  logic [7:0] s_data[$];
  int         s_cyc[$];
  bit         s_gid[$];
  int na0, na1, nd0, nd1, ld1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clr_log;
    s_data.delete(); s_cyc.delete(); s_gid.delete();
    na0 = 0; na1 = 0; nd0 = 0; nd1 = 0; ld1 = -1;
  endtask

  task automatic drive(input bit r0, input logic [7:0] d0, input bit r1, input logic [7:0] d1);
    @(posedge clk); #2;
    req0 = r0; data0 = d0; req1 = r1; data1 = d1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic do_reset;
    @(posedge clk); #2;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    clr_log();
  endtask

  // Reference model: each byte is a transfer with a start timestamp; its release time follows from the busy history
  initial begin
    int c, p;
    bit g, w;
    forever begin
      @(posedge clk);
      cyc++;
      c = cyc;
      p = c - 1;
      if (reset) begin
        m_ok = 1'b1; mp0 = 1'b0; mp1 = 1'b0; m_xfer = 1'b0; m_free = -1;
        e_start = 1'b0; e_data = 8'h00; e_gid = 1'b1; e_ack0 = 1'b0; e_ack1 = 1'b0;
        e_drop0 = 1'b0; e_drop1 = 1'b0; e_active = 1'b0;
      end else if (m_ok) begin
        if (m_xfer && m_free < 0 && p > m_S) begin
          if (!m_rise) begin
            if (tx_busy) begin m_rise = 1'b1; m_rise_cyc = p; end
            else if (p - m_S >= BT) m_free = p + 1 + G;
          end else if (p > m_rise_cyc && !tx_busy) begin
            m_free = p + 1 + G;
          end
        end
        if (m_xfer && m_free >= 0 && p >= m_free) m_xfer = 1'b0;
        g = !m_xfer && !tx_busy && (mp0 || mp1);
        w = (mp0 && mp1) ? (RR ? !e_gid : 1'b0) : mp1;
        e_ack0 = g && !w;
        e_ack1 = g && w;
        if (g) begin
          e_data = w ? md1 : md0;
          e_gid  = w;
          if (w) mp1 = 1'b0; else mp0 = 1'b0;
          m_xfer = 1'b1; m_S = c; m_rise = 1'b0; m_free = -1;
        end
        e_drop0 = req0 && mp0;
        if (req0 && !mp0) begin mp0 = 1'b1; md0 = data0; end
        e_drop1 = req1 && mp1;
        if (req1 && !mp1) begin mp1 = 1'b1; md1 = data1; end
        e_start  = m_xfer && (c == m_S);
        e_active = m_xfer && !(m_free >= 0 && c >= m_free);
      end
    end
  end

  // Transmitter stand-in: busy rises rsp_delay cycles after tx_start for rsp_len cycles (delay 0 = never)
  initial begin
    int d, l;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_start === 1'b1) begin
        if (rsp_rand) begin
          d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, BT + 3));
          l = int'($urandom_range(1, 6));
        end else begin
          d = rsp_delay;
          l = rsp_len;
        end
        if (d == 0) begin rise_at = -1; fall_at = -1; end
        else begin rise_at = cyc + d; fall_at = rise_at + l; end
      end
      tx_busy = (rise_at >= 0) && (cyc >= rise_at) && (cyc < fall_at);
    end
  end

  // Per-cycle compare against the model, plus event logging
  initial begin
    logic [14:0] got, exp;
    forever begin
      @(negedge clk);
      if (m_ok) begin
        got = {tx_start, tx_data, grant_id, ack0, ack1, drop0, drop1, active};
        exp = {e_start, e_data, e_gid, e_ack0, e_ack1, e_drop0, e_drop1, e_active};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL outputs cyc %0d: got start=%b data=%h gid=%b ack=%b%b drop=%b%b act=%b, required start=%b data=%h gid=%b ack=%b%b drop=%b%b act=%b",
                   cyc, got[14], got[13:6], got[5], got[4], got[3], got[2], got[1], got[0],
                   exp[14], exp[13:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
      end
      if (tx_start === 1'b1) begin
        tests++;
        if (tx_busy !== 1'b0) begin
          fails++;
          $display("FAIL start_while_busy cyc %0d: got tx_busy=%b, required 0", cyc, tx_busy);
        end
        s_data.push_back(tx_data); s_cyc.push_back(cyc); s_gid.push_back(grant_id);
      end
      if (ack0 === 1'b1) na0++;
      if (ack1 === 1'b1) na1++;
      if (drop0 === 1'b1) nd0++;
      if (drop1 === 1'b1) begin nd1++; ld1 = cyc; end
    end
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: got no end of stimulus, required end before time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int q, q2, n;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    clr_log();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_active", int'(active), 0);
    chk("reset_data", int'(tx_data), 8'h00);
    chk("reset_gid", int'(grant_id), 1);
    reset = 1'b0;

    // single byte, busy after 3 cycles for 20, follow-up byte waits out the gap
    do_reset();
    rsp_delay = 3; rsp_len = 20;
    drive(1'b1, 8'h41, 1'b0, 8'h00); q = cyc;
    idle(2);
    drive(1'b1, 8'h42, 1'b0, 8'h00);
    idle(80);
    chk("s1_count", s_data.size(), 2);
    chk("s1_latency", s_cyc[0] - q, 2);
    chk("s1_data", int'(s_data[0]), 8'h41);
    chk("s1_gid", int'(s_gid[0]), 0);
    chk("s1_acks", na0, 2);
    chk("s1_spacing", s_cyc[1] - s_cyc[0], 41);
    chk("s1_data2", int'(s_data[1]), 8'h42);

    // simultaneous requests, then a second contested round
    do_reset();
    rsp_delay = 2; rsp_len = 3;
    drive(1'b1, 8'h31, 1'b1, 8'h32);
    idle(60);
    drive(1'b1, 8'h33, 1'b0, 8'h00); q2 = cyc;
    idle(3);
    drive(1'b1, 8'h35, 1'b1, 8'h34);
    idle(80);
    chk("s2_count", s_data.size(), 5);
    chk("s2_first", int'(s_data[0]), 8'h31);
    chk("s2_second", int'(s_data[1]), 8'h32);
    chk("s2_third", int'(s_data[2]), 8'h33);
    chk("s2_fourth", int'(s_data[3]), RR ? 8'h34 : 8'h35);
    chk("s2_fifth", int'(s_data[4]), RR ? 8'h35 : 8'h34);
    chk("s2_third_lat", s_cyc[2] - q2, 2);

    // second strobe on a still-pending slot is dropped
    do_reset();
    drive(1'b1, 8'h10, 1'b0, 8'h00); q = cyc;
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    drive(1'b0, 8'h00, 1'b1, 8'h55);
    drive(1'b0, 8'h00, 1'b1, 8'hAA);
    idle(60);
    chk("s3_drops", nd1, 1);
    chk("s3_drop_cyc", ld1 - q, 4);
    chk("s3_count", s_data.size(), 2);
    chk("s3_sent", int'(s_data[1]), 8'h55);

    // transmitter never answers: timeout plus gap, then the other slot goes
    do_reset();
    rsp_delay = 0;
    drive(1'b1, 8'h60, 1'b1, 8'h61);
    idle(70);
    chk("s4_count", s_data.size(), 2);
    chk("s4_first", int'(s_data[0]), 8'h60);
    chk("s4_second", int'(s_data[1]), 8'h61);
    chk("s4_spacing", s_cyc[1] - s_cyc[0], 26);

    // reset while the byte is on the wire
    do_reset();
    rsp_delay = 2; rsp_len = 30;
    drive(1'b1, 8'h70, 1'b0, 8'h00);
    idle(7);
    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
    chk("s5_active", int'(active), 0);
    chk("s5_data", int'(tx_data), 8'h00);
    chk("s5_gid", int'(grant_id), 1);
    chk("s5_start", int'(tx_start), 0);
    n = s_data.size();
    idle(40);
    chk("s5_no_restart", s_data.size(), n);

    // new strobe in the very cycle its slot is granted
    do_reset();
    rsp_delay = 1; rsp_len = 4;
    drive(1'b1, 8'h80, 1'b0, 8'h00);
    drive(1'b1, 8'h81, 1'b0, 8'h00);
    idle(50);
    chk("s6_drops", nd0, 0);
    chk("s6_count", s_data.size(), 2);
    chk("s6_second", int'(s_data[1]), 8'h81);
    chk("s6_spacing", s_cyc[1] - s_cyc[0], 23);

    // randomized traffic, responder timing and occasional resets
    rsp_rand = 1'b1;
    repeat (3000) begin
      @(posedge clk); #2;
      reset = ($urandom_range(0, 699) == 0);
      req0  = ($urandom_range(0, 5) == 0);
      data0 = 8'($urandom);
      req1  = ($urandom_range(0, 5) == 0);
      data1 = 8'($urandom);
    end
    @(posedge clk); #2;
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    idle(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
